// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared definitions for the IFU thread scheduler.
// Holds the per-thread FSM state encodings, the scheduler control FSM
// encodings, the default fairness quantum and a one-hot-to-index helper.
package sparc_ifu_thrsched_pkg;

  // Per-thread FSM state encodings (as driven by the per-thread FSMs).
  localparam logic [4:0] ThrIdle    = 5'b00000;
  localparam logic [4:0] ThrHalt    = 5'b00010;
  localparam logic [4:0] ThrWait    = 5'b00001;
  localparam logic [4:0] ThrRdy     = 5'b11001;
  localparam logic [4:0] ThrSpecRdy = 5'b10011;
  localparam logic [4:0] ThrRun     = 5'b00101;
  localparam logic [4:0] ThrSpecRun = 5'b00111;

  // Scheduler control FSM.
  typedef enum logic [1:0] {
    StScan   = 2'b00,
    StIssue  = 2'b01,
    StSettle = 2'b10
  } sched_st_e;

  localparam int unsigned QuantumDefault = 16;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sparc_ifu_rrpick4.sv
// Combinational 4-way round-robin picker.
// Ports:
//   req     in  4  request vector
//   ptr     in  2  last granted index; search starts at ptr+1
//   gnt     out 4  one-hot grant (zero when no request)
//   gnt_vld out 1  some request was granted
module sparc_ifu_rrpick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       gnt_vld
);

  logic [1:0] idx;

  // Search order ptr+1, ptr+2, ptr+3, ptr (2-bit wrap makes i=4 land on ptr).
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// Per-core thread scheduler: producer end of the per-thread FSM interface.
// Watches four per-thread state codes, picks the next ready thread
// round-robin, pulses its one-hot schedule bit and raises switch_out when a
// running thread is displaced. A fairness quantum forces a switch when a
// thread has run for QUANTUM scan cycles while a peer was ready.
//
// Optional feature macro: SPARC_IFU_THRSCHED_SPEC_EN
//   defined   - SPEC_RDY threads are eligible below RDY threads
//   undefined - only RDY threads are eligible
//
// Ports:
//   clk                  in  1  clock
//   reset                in  1  synchronous, active-high
//   thr_state0..3        in  5  per-thread FSM state
//   fcl_hold             in  1  pipeline hold; blocks new decisions
//   sw_req               in  1  request to switch the running thread
//   schedule             out 4  one-hot pulse selecting the thread to run
//   switch_out           out 1  running thread returns to ready
//   cur_thr              out 2  last scheduled thread
//   cur_vld              out 1  some thread is in a run-type state
//   qexp                 out 1  quantum expired (single-cycle pulse)
module sparc_ifu_thrsched
  import sparc_ifu_thrsched_pkg::*;
#(
  parameter int unsigned QUANTUM = QuantumDefault,
  parameter int unsigned QW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] thr_state0,
  input  logic [4:0] thr_state1,
  input  logic [4:0] thr_state2,
  input  logic [4:0] thr_state3,
  input  logic       fcl_hold,
  input  logic       sw_req,
  output logic [3:0] schedule,
  output logic       switch_out,
  output logic [1:0] cur_thr,
  output logic       cur_vld,
  output logic       qexp
);

  localparam logic [QW-1:0] QMax = QW'(QUANTUM);

  logic [3:0][4:0] thr_st;
  logic [3:0]      rdy_req;
  logic [3:0]      run_vec;

  assign thr_st = {thr_state3, thr_state2, thr_state1, thr_state0};

  sched_st_e       state_q, state_d;
  logic [1:0]      rr_q, rr_d;
  logic [QW-1:0]   cnt_q, cnt_d;
  logic [3:0]      sched_q, sched_d;
  logic            sw_q, sw_d;
  logic [1:0]      cur_thr_q, cur_thr_d;
  logic            cur_vld_q, cur_vld_d;
  logic            qexp_q, qexp_d;

  logic [3:0]      rdy_gnt, pick_gnt;
  logic            rdy_vld, elig_vld;
  logic            any_run, expired, decide;

  always_comb begin
    rdy_req = '0;
    run_vec = '0;
    for (int i = 0; i < 4; i++) begin
      rdy_req[i] = (thr_st[i] == ThrRdy);
      run_vec[i] = (thr_st[i] == ThrRun) || (thr_st[i] == ThrSpecRun);
    end
  end

  sparc_ifu_rrpick4 u_pick_rdy (
    .req     (rdy_req),
    .ptr     (rr_q),
    .gnt     (rdy_gnt),
    .gnt_vld (rdy_vld)
  );

`ifdef SPARC_IFU_THRSCHED_SPEC_EN
  logic [3:0] spec_req;
  logic [3:0] spec_gnt;
  logic       spec_vld;

  always_comb begin
    spec_req = '0;
    for (int i = 0; i < 4; i++) begin
      spec_req[i] = (thr_st[i] == ThrSpecRdy);
    end
  end

  sparc_ifu_rrpick4 u_pick_spec (
    .req     (spec_req),
    .ptr     (rr_q),
    .gnt     (spec_gnt),
    .gnt_vld (spec_vld)
  );

  // Speculative-ready threads only win when no fully ready thread exists.
  assign pick_gnt = rdy_vld ? rdy_gnt : spec_gnt;
  assign elig_vld = rdy_vld | spec_vld;
`else
  assign pick_gnt = rdy_gnt;
  assign elig_vld = rdy_vld;
`endif

  assign any_run = |run_vec;
  assign expired = (cnt_q == QMax);
  assign decide  = (state_q == StScan) && !fcl_hold && elig_vld &&
                   (!any_run || sw_req || expired);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    sched_d   = '0;
    sw_d      = 1'b0;
    cur_thr_d = cur_thr_q;
    cur_vld_d = any_run;
    unique case (state_q)
      StScan: begin
        if (decide) begin
          // Outputs are registered, so the ISSUE-cycle values load here.
          state_d   = StIssue;
          sched_d   = pick_gnt;
          sw_d      = any_run;
          cur_thr_d = oh2idx(pick_gnt);
          rr_d      = oh2idx(pick_gnt);
          cnt_d     = '0;
        end else if (!fcl_hold) begin
          if (any_run && elig_vld) begin
            cnt_d = expired ? cnt_q : cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
          end
        end
      end
      StIssue:  state_d = StSettle;
      StSettle: state_d = StScan;
      default:  state_d = StScan;
    endcase
    // Pulse only on the transition into the expired count.
    qexp_d = (cnt_d == QMax) && !expired;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StScan;
      rr_q      <= 2'd3;
      cnt_q     <= '0;
      sched_q   <= '0;
      sw_q      <= 1'b0;
      cur_thr_q <= '0;
      cur_vld_q <= 1'b0;
      qexp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      sched_q   <= sched_d;
      sw_q      <= sw_d;
      cur_thr_q <= cur_thr_d;
      cur_vld_q <= cur_vld_d;
      qexp_q    <= qexp_d;
    end
  end

  assign schedule   = sched_q;
  assign switch_out = sw_q;
  assign cur_thr    = cur_thr_q;
  assign cur_vld    = cur_vld_q;
  assign qexp       = qexp_q;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Self-checking bench for sparc_ifu_thrsched: directed scenarios plus a
// randomized run, all checked against a cycle-level reference model.
module tb_sparc_ifu_thrsched;

  localparam logic [4:0] SIdle    = 5'b00000;
  localparam logic [4:0] SHalt    = 5'b00010;
  localparam logic [4:0] SWait    = 5'b00001;
  localparam logic [4:0] SRdy     = 5'b11001;
  localparam logic [4:0] SSpecRdy = 5'b10011;
  localparam logic [4:0] SRun     = 5'b00101;
  localparam logic [4:0] SSpecRun = 5'b00111;
  localparam int         Q        = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ts [4];
  logic       fcl_hold, sw_req;
  logic [3:0] schedule;
  logic       switch_out, cur_vld, qexp;
  logic [1:0] cur_thr;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  int         m_phase, m_rr, m_cnt;
  logic [3:0] m_sched;
  logic       m_sw, m_vld, m_qexp;
  logic [1:0] m_cur;

  logic [8:0] act, expv;
  assign act  = {schedule, switch_out, cur_thr, cur_vld, qexp};
  assign expv = {m_sched, m_sw, m_cur, m_vld, m_qexp};

  sparc_ifu_thrsched dut (
    .clk        (clk),
    .reset      (reset),
    .thr_state0 (ts[0]),
    .thr_state1 (ts[1]),
    .thr_state2 (ts[2]),
    .thr_state3 (ts[3]),
    .fcl_hold   (fcl_hold),
    .sw_req     (sw_req),
    .schedule   (schedule),
    .switch_out (switch_out),
    .cur_thr    (cur_thr),
    .cur_vld    (cur_vld),
    .qexp       (qexp)
  );

  always #5 clk = ~clk;

  // One clock of the scheduler, expressed in terms of the behavioural rules.
  task automatic model_update();
    bit rdy[4], spec[4];
    bit any_run, any_elig;
    int pick, j, nc;
    if (reset) begin
      m_phase = 0; m_rr = 3; m_cnt = 0;
      m_sched = '0; m_sw = 0; m_cur = '0; m_vld = 0; m_qexp = 0;
      return;
    end
    any_run = 0; any_elig = 0;
    for (int i = 0; i < 4; i++) begin
      rdy[i] = (ts[i] == SRdy);
`ifdef SPARC_IFU_THRSCHED_SPEC_EN
      spec[i] = (ts[i] == SSpecRdy);
`else
      spec[i] = 0;
`endif
      if (ts[i] == SRun || ts[i] == SSpecRun) any_run = 1;
      if (rdy[i] || spec[i]) any_elig = 1;
    end
    m_vld = any_run; m_sched = '0; m_sw = 0; m_qexp = 0;
    if (m_phase == 0) begin
      if (!fcl_hold && any_elig && (!any_run || sw_req || m_cnt == Q)) begin
        pick = -1;
        for (int k = 1; k <= 4; k++) begin
          j = (m_rr + k) % 4;
          if (pick < 0 && rdy[j]) pick = j;
        end
        for (int k = 1; k <= 4; k++) begin
          j = (m_rr + k) % 4;
          if (pick < 0 && spec[j]) pick = j;
        end
        m_sched = 4'(1 << pick); m_sw = any_run; m_cur = 2'(pick);
        m_rr = pick; m_cnt = 0; m_phase = 1;
      end else if (!fcl_hold) begin
        if (any_run && any_elig) begin
          nc = (m_cnt + 1 > Q) ? Q : m_cnt + 1;
          m_qexp = (nc == Q) && (m_cnt != Q);
          m_cnt = nc;
        end else begin
          m_cnt = 0;
        end
      end
    end else begin
      m_phase = (m_phase == 1) ? 2 : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_all(input logic [4:0] a0, a1, a2, a3);
    ts[0] = a0; ts[1] = a1; ts[2] = a2; ts[3] = a3;
  endtask

  task automatic apply_reset();
    reset = 1'b1; fcl_hold = 1'b0; sw_req = 1'b0;
    set_all(SIdle, SIdle, SIdle, SIdle);
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (act !== 9'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", act, 9'b0);
    end
    vectors++;
    if (act !== expv) begin
      errors++; $display("FAIL reset_model got=%b exp=%b", act, expv);
    end
  endtask

  task automatic test_first_pick();
    apply_reset();
    set_all(SRdy, SIdle, SIdle, SIdle);
    step();
    vectors++;
    if (schedule !== 4'b0001 || switch_out !== 1'b0 || cur_thr !== 2'd0) begin
      errors++;
      $display("FAIL first_pick got sched=%b sw=%b thr=%0d exp sched=0001 sw=0 thr=0",
               schedule, switch_out, cur_thr);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (act !== expv) begin
        errors++; $display("FAIL first_pick_tail c=%0d got=%b exp=%b", c, act, expv);
      end
    end
  endtask

  task automatic test_quantum();
    apply_reset();
    set_all(SRun, SIdle, SRdy, SIdle);
    for (int c = 1; c <= Q; c++) begin
      step();
      vectors++;
      if (act !== expv || qexp !== (c == Q)) begin
        errors++; $display("FAIL quantum c=%0d got=%b exp=%b", c, act, expv);
      end
    end
    step();
    vectors++;
    if (schedule !== 4'b0100 || switch_out !== 1'b1) begin
      errors++;
      $display("FAIL quantum_switch got sched=%b sw=%b exp sched=0100 sw=1",
               schedule, switch_out);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_all(SIdle, SRdy, SIdle, SIdle);
    step();
    vectors++;
    if (schedule !== 4'b0010) begin
      errors++; $display("FAIL rr_seed got=%b exp=0010", schedule);
    end
    step(); step();
    set_all(SRdy, SRdy, SIdle, SRdy);
    step();
    vectors++;
    if (schedule !== 4'b1000 || switch_out !== 1'b0) begin
      errors++; $display("FAIL rr_pick_t3 got sched=%b sw=%b exp 1000/0", schedule, switch_out);
    end
    step(); step();
    set_all(SRdy, SRdy, SIdle, SRun);
    sw_req = 1'b1;
    step();
    vectors++;
    if (schedule !== 4'b0001 || switch_out !== 1'b1 || cur_thr !== 2'd0) begin
      errors++;
      $display("FAIL rr_pick_t0 got sched=%b sw=%b thr=%0d exp 0001/1/0",
               schedule, switch_out, cur_thr);
    end
    sw_req = 1'b0;
  endtask

  task automatic test_hold();
    apply_reset();
    set_all(SRdy, SRun, SIdle, SIdle);
    // Let the quantum counter advance partway, then freeze it under hold.
    for (int c = 0; c < 10; c++) step();
    fcl_hold = 1'b1; sw_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if (schedule !== 4'b0000 || qexp !== 1'b0 || act !== expv) begin
        errors++; $display("FAIL hold c=%0d got=%b exp=%b", c, act, expv);
      end
    end
    fcl_hold = 1'b0;
    step();
    vectors++;
    if (schedule !== 4'b0001 || switch_out !== 1'b1) begin
      errors++; $display("FAIL hold_release got sched=%b sw=%b exp 0001/1", schedule, switch_out);
    end
    sw_req = 1'b0;
  endtask

  task automatic test_spec();
    logic [3:0] first_exp;
    logic       seen;
    apply_reset();
    set_all(SIdle, SSpecRdy, SRdy, SIdle);
    step();
    vectors++;
    if (schedule !== 4'b0100) begin
      errors++; $display("FAIL spec_class got=%b exp=0100", schedule);
    end
    step(); step();
    set_all(SIdle, SSpecRdy, SIdle, SIdle);
`ifdef SPARC_IFU_THRSCHED_SPEC_EN
    first_exp = 4'b0010;
`else
    first_exp = 4'b0000;
`endif
    step();
    vectors++;
    if (schedule !== first_exp) begin
      errors++; $display("FAIL spec_only got=%b exp=%b", schedule, first_exp);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (schedule != 4'b0000) seen = 1'b1;
      vectors++;
      if (act !== expv) begin
        errors++; $display("FAIL spec_only_tail c=%0d got=%b exp=%b", c, act, expv);
      end
    end
`ifndef SPARC_IFU_THRSCHED_SPEC_EN
    vectors++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL spec_ignored got=%b exp=0", seen);
    end
`endif
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    set_all(SIdle, SRdy, SIdle, SIdle);
    step();
    vectors++;
    if (schedule !== 4'b0010) begin
      errors++; $display("FAIL mid_issue_setup got=%b exp=0010", schedule);
    end
    reset = 1'b1;
    step();
    vectors++;
    if (act !== 9'b0) begin
      errors++; $display("FAIL mid_issue_reset got=%b exp=%b", act, 9'b0);
    end
    reset = 1'b0;
    set_all(SRdy, SRdy, SIdle, SIdle);
    step();
    vectors++;
    if (schedule !== 4'b0001 || cur_thr !== 2'd0) begin
      errors++; $display("FAIL post_reset_pick got sched=%b thr=%0d exp 0001/0", schedule, cur_thr);
    end
  endtask

  task automatic test_random();
    logic [4:0] tbl [8];
    tbl[0] = SIdle; tbl[1] = SHalt; tbl[2] = SWait; tbl[3] = SRdy;
    tbl[4] = SSpecRdy; tbl[5] = SRun; tbl[6] = SSpecRun; tbl[7] = 5'b11111;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0) ts[i] = tbl[$urandom_range(7)];
      end
      fcl_hold = ($urandom_range(4) == 0);
      sw_req   = ($urandom_range(5) == 0);
      reset    = ($urandom_range(79) == 0);
      step();
      vectors++;
      if (act !== expv) begin
        errors++; $display("FAIL random c=%0d got=%b exp=%b", c, act, expv);
      end
    end
    reset = 1'b0; fcl_hold = 1'b0; sw_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fcl_hold = 1'b0; sw_req = 1'b0;
    set_all(SIdle, SIdle, SIdle, SIdle);
    m_phase = 0; m_rr = 3; m_cnt = 0;
    m_sched = '0; m_sw = 0; m_cur = '0; m_vld = 0; m_qexp = 0;
    test_reset();
    test_first_pick();
    test_quantum();
    test_round_robin();
    test_hold();
    test_spec();
    test_reset_mid_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sparc_ifu_thrsched.md
Name: sparc_ifu_thrsched

Overview:
- Per-core thread scheduler; the producer end of the per-thread FSM interface.
- Observes all four per-thread 5-bit states.
- Picks the next ready thread round-robin, pulses its one-hot schedule bit, and asserts the common switch_out when displacing a running thread.
- Enforces a fairness quantum so one running thread cannot starve ready peers.

Parameters:
- QUANTUM, 16: cycles a thread may run while another thread is ready before a forced switch; legal 2..255.
- QW, 8: quantum counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- thr_state0..thr_state3  in  5 each  current per-thread FSM state.
- fcl_hold  in  1  pipeline hold; no new decision while high.
- sw_req  in  1  fetch control requests a switch of the running thread (e.g. long-latency op pending).
- schedule  out  4  one-hot; pulse selects the thread to run.
- switch_out  out  1  common; running thread returns to ready.
- cur_thr  out  2  last scheduled thread.
- cur_vld  out  1  a thread is in a run-type state.
- qexp  out  1  quantum expired this cycle (debug/perf).

Behaviour:
- State encodings are fixed as follows.
  - IDLE 00000, HALT 00010, WAIT 00001.
  - RDY 11001, SPEC_RDY 10011.
  - RUN 00101, SPEC_RUN 00111.
- Classification:
  - Ready-type: exactly RDY, or SPEC_RDY (SPEC_RDY only per Optional Feature).
  - Run-type: exactly RUN or SPEC_RUN.
  - Any other code is neither.
- All outputs are registered.
- Reset values: schedule=0, switch_out=0, cur_thr=0, cur_vld=0, qexp=0, rr pointer=3 (so thread 0 has first priority), quantum counter=0, FSM=SCAN.
- Control FSM has three states: SCAN, ISSUE, SETTLE.
- SCAN:
  - Decision condition, all of:
    - ~fcl_hold;
    - at least one eligible ready thread;
    - one of: no run-type thread, OR sw_req, OR quantum expired.
  - If the condition holds: pick = first eligible thread in order rr+1, rr+2, rr+3, rr (mod 4); go to ISSUE.
  - A running thread is never re-picked; it is not ready-type.
- ISSUE (exactly 1 cycle):
  - schedule[pick]=1.
  - switch_out=1 iff a run-type thread existed at the decision.
  - cur_thr<=pick; rr<=pick; counter cleared.
  - Next state is SETTLE.
- SETTLE (exactly 1 cycle): schedule=0, switch_out=0; lets thread states update; then return to SCAN.
- Latency:
  - Decision to schedule pulse: 1 cycle.
  - Back-to-back picks: at most one every 3 cycles.
- cur_vld = registered OR of run-type over all threads.
- Quantum counter:
  - Increments in SCAN while a run-type thread exists and some other thread is eligible; otherwise holds at 0.
  - Saturates at QUANTUM.
  - Expired when counter==QUANTUM; qexp pulses 1 cycle on reaching it.
- Boundary conditions:
  - fcl_hold high in SCAN: counter holds, no pick.
  - fcl_hold does not abort ISSUE or SETTLE.
  - Picked thread stalled to WAIT in the same cycle as its schedule pulse: not an error; next SCAN re-evaluates.
  - Multiple run-type threads (illegal): cur_vld=1; switch_out still issued on the next pick.
  - No ready threads: stay in SCAN indefinitely; counter held at 0.
  - Reset mid-ISSUE: outputs drop to 0 the next cycle; no residual pulse.

Optional Feature:
- Macro: SPARC_IFU_THRSCHED_SPEC_EN.
- Defined:
  - SPEC_RDY threads are eligible, at lower priority than RDY threads.
  - A SPEC_RDY thread is picked only when no RDY thread exists; round-robin applies within each class.
- Undefined: only RDY is eligible; SPEC_RDY is treated as not ready.

Decomposition:
- Shared header holds:
  - the seven thread-state encodings;
  - the scheduler FSM encodings (SCAN 2'b00, ISSUE 2'b01, SETTLE 2'b10);
  - the QUANTUM default.
- One sub-module, sparc_ifu_rrpick4:
  - combinational 4-way round-robin picker;
  - inputs req[3:0], ptr[1:0]; outputs gnt[3:0] one-hot, gnt_vld;
  - instantiated once, or twice for the two priority classes when SPARC_IFU_THRSCHED_SPEC_EN is defined.

Test Plan:
- Reset, then thr_state0=RDY, others IDLE -> schedule=0001 two cycles after reset deasserts (decision cycle + ISSUE); switch_out=0; cur_thr=0.
- T0=RUN, T2=RDY, QUANTUM=16, no sw_req -> after 16 SCAN cycles qexp=1; next cycle schedule=0100, switch_out=1.
- rr=1, T0/T1/T3=RDY, none running -> schedule=1000 (T3 picked); next pick after T3 runs with sw_req=1 -> 0001.
- T1=RUN, T0=RDY, fcl_hold=1 with sw_req=1 for 10 cycles -> schedule stays 0; counter frozen; hold drops -> schedule=0001, switch_out=1 next cycle.
- With SPARC_IFU_THRSCHED_SPEC_EN: T1=SPEC_RDY, T2=RDY, none running -> schedule=0100; without the macro, T1=SPEC_RDY only -> schedule never asserts.
- Assert reset during ISSUE (schedule=0010) -> next cycle all outputs 0; rr restored so thread 0 wins the first post-reset pick.
